n1_mem_arbiter: RTL

- Shares the single-port 16-bit program/data RAM of the n1 core between three requesters:
  - the external loader (programming/debug port),
  - the instruction-fetch unit,
  - the data-memory unit (store/print instructions).
- Registered fixed-priority plus round-robin arbiter with one-cycle-latency read return routing and a saturating contention counter.
- Sits between the core's fetch/execute logic and the RAM macro.

---
 rtl/n1_mem_arbiter.sv | 121 ++++++++++++
 1 files changed

// File: rtl/n1_mem_arbiter.sv
// Shares the n1 single-port RAM between loader, fetch and data ports.
// Loader has strict priority; fetch/data alternate; reads return one cycle after the grant.
module n1_mem_arbiter #(
  parameter int unsigned ADDR_BITS = 7,
  parameter int unsigned DATA_BITS = 16,
  parameter int unsigned CNT_BITS  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ld_req,
  input  logic                 ld_we,
  input  logic [ADDR_BITS-1:0] ld_addr,
  input  logic [DATA_BITS-1:0] ld_wdata,
  output logic                 ld_gnt,
  output logic                 ld_rvalid,
  input  logic                 if_req,
  input  logic [ADDR_BITS-1:0] if_addr,
  output logic                 if_gnt,
  output logic                 if_rvalid,
  input  logic                 dm_req,
  input  logic                 dm_we,
  input  logic [ADDR_BITS-1:0] dm_addr,
  input  logic [DATA_BITS-1:0] dm_wdata,
  output logic                 dm_gnt,
  output logic                 dm_rvalid,
  output logic [DATA_BITS-1:0] rdata,
  output logic                 mem_en,
  output logic                 mem_we,
  output logic [ADDR_BITS-1:0] mem_addr,
  output logic [DATA_BITS-1:0] mem_wdata,
  input  logic [DATA_BITS-1:0] mem_rdata,
  output logic [CNT_BITS-1:0]  conflict_cnt
);

  // Requester index within the 3-bit vectors: 0 loader, 1 fetch, 2 data.
  logic [2:0]           gnt_q, gnt_d;
  logic [2:0]           rvalid_q, rvalid_d;
  logic                 fav_dm_q, fav_dm_d;
  logic                 mem_we_q, mem_we_d;
  logic [ADDR_BITS-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_BITS-1:0] mem_wdata_q, mem_wdata_d;
  logic [CNT_BITS-1:0]  cnt_q, cnt_d;
  logic [2:0]           eff_c;
  logic                 contended_c;

  assign eff_c = {dm_req & ~gnt_q[2], if_req & ~gnt_q[1], ld_req & ~gnt_q[0]};
  assign contended_c = (eff_c[0] & eff_c[1]) | (eff_c[0] & eff_c[2]) | (eff_c[1] & eff_c[2]);

  // Winner selection, RAM command capture and read-return routing.
  always_comb begin
    gnt_d       = 3'b000;
    fav_dm_d    = fav_dm_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rvalid_d    = gnt_q & {3{~mem_we_q}};
    cnt_d       = cnt_q;

    if (eff_c[0]) begin
      gnt_d = 3'b001;
    end else if (eff_c[1] && eff_c[2]) begin
      gnt_d = fav_dm_q ? 3'b100 : 3'b010;
    end else if (eff_c[1]) begin
      gnt_d = 3'b010;
    end else if (eff_c[2]) begin
      gnt_d = 3'b100;
    end

    if (gnt_d[0]) begin
      mem_we_d    = ld_we;
      mem_addr_d  = ld_addr;
      mem_wdata_d = ld_wdata;
    end else if (gnt_d[1]) begin
      mem_addr_d  = if_addr;
      fav_dm_d    = 1'b1;
    end else if (gnt_d[2]) begin
      mem_we_d    = dm_we;
      mem_addr_d  = dm_addr;
      mem_wdata_d = dm_wdata;
      fav_dm_d    = 1'b0;
    end

    if (contended_c && (cnt_q != {CNT_BITS{1'b1}})) begin
      cnt_d = cnt_q + CNT_BITS'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt_q       <= 3'b000;
      rvalid_q    <= 3'b000;
      fav_dm_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      cnt_q       <= '0;
    end else begin
      gnt_q       <= gnt_d;
      rvalid_q    <= rvalid_d;
      fav_dm_q    <= fav_dm_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      cnt_q       <= cnt_d;
    end
  end

  assign ld_gnt       = gnt_q[0];
  assign if_gnt       = gnt_q[1];
  assign dm_gnt       = gnt_q[2];
  assign ld_rvalid    = rvalid_q[0];
  assign if_rvalid    = rvalid_q[1];
  assign dm_rvalid    = rvalid_q[2];
  assign rdata        = mem_rdata;
  assign mem_en       = |gnt_q;
  assign mem_we       = mem_we_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;
  assign conflict_cnt = cnt_q;

endmodule
